// File: rtl/fw_drain.sv
// Receive-side unpacker for the fw result stream: buffers one NxN matrix of
// packed words, then serialises tagged elements while stalling fw via inhibit.
module fw_drain #(
    parameter int ELEM_W = 16,
    parameter int LANES  = 4,
    parameter int N      = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ELEM_W*LANES-1:0]  inD,
    input  logic                     in_valid,
    output logic                     inhibit,
    output logic [ELEM_W-1:0]        elem_data,
    output logic [IDX_W-1:0]         elem_row,
    output logic [IDX_W-1:0]         elem_col,
    output logic                     elem_valid,
    input  logic                     elem_ready,
    output logic                     elem_last,
    output logic                     overflow,
    output logic [7:0]               mat_count
);

    localparam int WORDS   = N * N / LANES;
    localparam int WORD_AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [WORD_AW-1:0]        wr_ptr;
    logic [WORD_AW-1:0]        rd_word;
    logic [LANE_W-1:0]         rd_lane;
    logic [IDX_W-1:0]          row;
    logic [IDX_W-1:0]          col;
    logic [ELEM_W*LANES-1:0]   mem [WORDS];
    logic [ELEM_W*LANES-1:0]   rd_word_data;
    logic [ELEM_W-1:0]         rd_elem;
    logic                      last_el;
    logic                      fill_last;

    assign fill_last = (wr_ptr == WORD_AW'(WORDS - 1));
    assign last_el   = (row == IDX_W'(N - 1)) && (col == IDX_W'(N - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (in_valid && fill_last) state_nxt = DRAIN;
            DRAIN:   if (elem_ready && last_el) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Pointers, element tags and status; the read side tracks word/lane and
    // row/col as separate counters so no division is needed for any N.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_word   <= '0;
            rd_lane   <= '0;
            row       <= '0;
            col       <= '0;
            overflow  <= 1'b0;
            mat_count <= '0;
        end else if (state == FILL) begin
            if (in_valid) begin
                wr_ptr <= fill_last ? '0 : wr_ptr + WORD_AW'(1);
            end
        end else begin
            if (in_valid) begin
                overflow <= 1'b1;
            end
            if (elem_ready) begin
                if (last_el) begin
                    mat_count <= mat_count + 8'd1;
                    rd_word   <= '0;
                    rd_lane   <= '0;
                    row       <= '0;
                    col       <= '0;
                end else begin
                    if (rd_lane == LANE_W'(LANES - 1)) begin
                        rd_lane <= '0;
                        rd_word <= rd_word + WORD_AW'(1);
                    end else begin
                        rd_lane <= rd_lane + LANE_W'(1);
                    end
                    if (col == IDX_W'(N - 1)) begin
                        col <= '0;
                        row <= row + IDX_W'(1);
                    end else begin
                        col <= col + IDX_W'(1);
                    end
                end
            end
        end
    end

    // Matrix buffer: data only, no reset; beats arriving during DRAIN are dropped.
    always_ff @(posedge clk) begin
        if (state == FILL && in_valid) begin
            mem[wr_ptr] <= inD;
        end
    end

    always_comb begin
        rd_word_data = mem[rd_word];
        rd_elem      = '0;
        for (int k = 0; k < LANES; k++) begin
            if (rd_lane == LANE_W'(k)) begin
                rd_elem = rd_word_data[ELEM_W*k +: ELEM_W];
            end
        end
    end

    always_comb begin
        inhibit    = 1'b0;
        elem_valid = 1'b0;
        elem_data  = '0;
        elem_row   = '0;
        elem_col   = '0;
        elem_last  = 1'b0;
        if (state == DRAIN) begin
            inhibit    = 1'b1;
            elem_valid = 1'b1;
            elem_data  = rd_elem;
            elem_row   = row;
            elem_col   = col;
            elem_last  = last_el;
        end
    end

endmodule
